// File: rtl/calc_seq_n.sv
// calc_seq_n: keypad calculator with decimal entry, multi-cycle mul/div and a per-digit display scan.
// Optional build macro CALC_NEG_EN: negative subtraction results shown with a minus glyph in the top digit.
module calc_seq_n #(
  parameter int NDIG = 8,
  parameter int VW   = 27,
  parameter int PW   = $clog2(NDIG)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [3:0]    cmd,
  input  logic          cmd_valid,
  output logic [1:0]    status,
  output logic [3:0]    data,
  output logic [PW-1:0] pos,
  output logic [VW-1:0] value
);

  // state   | meaning
  // ENTRY_A | keying first operand (or chaining from a result)
  // ENTRY_B | keying second operand
  // EXEC    | running the stored operation
  // SCAN    | driving one digit per cycle on data/pos
  // ERR     | sticky error until reset
  typedef enum logic [2:0] {S_ENTRY_A, S_ENTRY_B, S_EXEC, S_SCAN, S_ERR} state_t;

  localparam int              CW     = $clog2(VW + 1);
  localparam logic [2*VW-1:0] MAXV   = (2*VW)'(10**NDIG - 1);
  localparam logic [2*VW-1:0] MAXN   = (2*VW)'(10**(NDIG-1) - 1);
  localparam logic [1:0]      OP_ADD = 2'd2;
  localparam logic [1:0]      OP_SUB = 2'd3;
  localparam logic [1:0]      OP_MUL = 2'd0;

  state_t          r_state, w_state_nxt;
  state_t          r_ret, w_ret_nxt;
  logic [VW-1:0]   r_value, w_value_nxt;
  logic [VW-1:0]   r_rega, w_rega_nxt;
  logic [VW-1:0]   r_regb, w_regb_nxt;
  logic [1:0]      r_op, w_op_nxt;
  logic            r_fresh, w_fresh_nxt;
  logic [VW-1:0]   r_shadow, w_shadow_nxt;
  logic [PW-1:0]   r_pos, w_pos_nxt;
  logic [CW-1:0]   r_cnt, w_cnt_nxt;
  logic [2*VW-1:0] r_acc, w_acc_nxt;
  logic [2*VW-1:0] r_mcand, w_mcand_nxt;
  logic [VW-1:0]   r_mplier, w_mplier_nxt;
  logic [VW-1:0]   r_rem, w_rem_nxt;
  logic [VW-1:0]   r_quo, w_quo_nxt;
`ifdef CALC_NEG_EN
  logic            r_neg, w_neg_nxt;
`endif

  logic            w_accept;
  logic [VW+3:0]   w_digit_ext;
  logic [VW-1:0]   w_value_div;
  logic [VW-1:0]   w_shadow_div;
  logic [3:0]      w_digit;
  logic [2*VW-1:0] w_mul_acc;
  logic [VW:0]     w_rem_sh;
  logic            w_div_ge;
  logic            w_done;
  logic            w_fail;
  logic            w_res_neg;
  logic [2*VW-1:0] w_res;

  assign w_accept     = cmd_valid && (r_state == S_ENTRY_A || r_state == S_ENTRY_B);
  assign w_digit_ext  = {4'd0, r_value} * (VW+4)'(10) + (VW+4)'(cmd);
  assign w_value_div  = r_value / VW'(10);
  assign w_shadow_div = r_shadow / VW'(10);
  assign w_digit      = 4'(r_shadow % VW'(10));
  assign w_mul_acc    = r_mplier[0] ? r_acc + r_mcand : r_acc;
  assign w_rem_sh     = {r_rem, r_quo[VW-1]};
  assign w_div_ge     = w_rem_sh >= {1'b0, r_regb};

  always_comb begin
    w_state_nxt  = r_state;
    w_ret_nxt    = r_ret;
    w_value_nxt  = r_value;
    w_rega_nxt   = r_rega;
    w_regb_nxt   = r_regb;
    w_op_nxt     = r_op;
    w_fresh_nxt  = r_fresh;
    w_shadow_nxt = r_shadow;
    w_pos_nxt    = r_pos;
    w_cnt_nxt    = r_cnt;
    w_acc_nxt    = r_acc;
    w_mcand_nxt  = r_mcand;
    w_mplier_nxt = r_mplier;
    w_rem_nxt    = r_rem;
    w_quo_nxt    = r_quo;
`ifdef CALC_NEG_EN
    w_neg_nxt    = r_neg;
`endif
    w_done       = 1'b0;
    w_fail       = 1'b0;
    w_res_neg    = 1'b0;
    w_res        = '0;
    status       = 2'b01;
    data         = 4'd0;

    case (r_state)
      S_ENTRY_A, S_ENTRY_B: begin
        status = 2'b10;
        if (w_accept) begin
          w_state_nxt = S_SCAN;
          w_ret_nxt   = r_state;
          w_pos_nxt   = '0;
          if (cmd <= 4'd9) begin
            if (r_fresh) begin
              w_value_nxt = VW'(cmd);
              w_fresh_nxt = 1'b0;
            end else if (w_digit_ext <= (VW+4)'(MAXV)) begin
              w_value_nxt = VW'(w_digit_ext);
            end
`ifdef CALC_NEG_EN
            w_neg_nxt = 1'b0;
`endif
          end else if (cmd == 4'd15) begin
            w_value_nxt = w_value_div;
          end else if (cmd == 4'd14) begin
            if (r_state == S_ENTRY_B) begin
              w_state_nxt  = S_EXEC;
              w_regb_nxt   = r_value;
              w_cnt_nxt    = CW'(VW - 1);
              w_acc_nxt    = '0;
              w_mcand_nxt  = (2*VW)'(r_rega);
              w_mplier_nxt = r_value;
              w_rem_nxt    = '0;
              w_quo_nxt    = r_rega;
            end
          end else begin
            w_fresh_nxt = 1'b0;
`ifdef CALC_NEG_EN
            w_neg_nxt   = 1'b0;
`endif
            if (r_state == S_ENTRY_A) begin
              w_rega_nxt  = r_value;
              w_op_nxt    = cmd[1:0];
              w_value_nxt = '0;
              w_ret_nxt   = S_ENTRY_B;
            end else begin
              w_fail = 1'b1;
            end
          end
          w_shadow_nxt = w_value_nxt;
        end
      end

      S_EXEC: begin
        w_cnt_nxt = r_cnt - CW'(1);
        case (r_op)
          OP_ADD: begin
            w_done = 1'b1;
            w_res  = (2*VW)'(r_rega) + (2*VW)'(r_regb);
          end
          OP_SUB: begin
            w_done = 1'b1;
            if (r_rega >= r_regb) begin
              w_res = (2*VW)'(r_rega - r_regb);
            end else begin
`ifdef CALC_NEG_EN
              w_res     = (2*VW)'(r_regb - r_rega);
              w_res_neg = 1'b1;
`else
              w_fail    = 1'b1;
`endif
            end
          end
          OP_MUL: begin
            w_acc_nxt    = w_mul_acc;
            w_mcand_nxt  = r_mcand << 1;
            w_mplier_nxt = r_mplier >> 1;
            w_done       = (r_cnt == '0);
            w_res        = w_mul_acc;
          end
          default: begin
            // restoring division: quotient bits shift in where the dividend shifts out
            w_rem_nxt = w_div_ge ? VW'(w_rem_sh - {1'b0, r_regb}) : VW'(w_rem_sh);
            w_quo_nxt = {r_quo[VW-2:0], w_div_ge};
            w_done    = (r_cnt == '0);
            w_res     = (2*VW)'({r_quo[VW-2:0], w_div_ge});
            if (r_regb == '0) w_fail = 1'b1;
          end
        endcase
        if (w_done && !w_fail) begin
          if (w_res > (w_res_neg ? MAXN : MAXV)) begin
            w_fail = 1'b1;
          end else begin
            w_value_nxt  = VW'(w_res);
            w_shadow_nxt = VW'(w_res);
            w_fresh_nxt  = 1'b1;
            w_state_nxt  = S_SCAN;
            w_ret_nxt    = S_ENTRY_A;
            w_pos_nxt    = '0;
`ifdef CALC_NEG_EN
            w_neg_nxt    = w_res_neg;
`endif
          end
        end
      end

      S_SCAN: begin
        data         = w_digit;
`ifdef CALC_NEG_EN
        if (r_neg && r_pos == PW'(NDIG - 1)) data = 4'hA;
`endif
        w_shadow_nxt = w_shadow_div;
        w_pos_nxt    = r_pos + PW'(1);
        if (r_pos == PW'(NDIG - 1)) begin
          w_pos_nxt   = '0;
          w_state_nxt = r_ret;
        end
      end

      default: status = 2'b00;
    endcase

    if (w_fail) begin
      w_state_nxt = S_ERR;
      w_value_nxt = '0;
      w_pos_nxt   = '0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state  <= S_SCAN;
      r_ret    <= S_ENTRY_A;
      r_value  <= '0;
      r_rega   <= '0;
      r_regb   <= '0;
      r_op     <= '0;
      r_fresh  <= 1'b0;
      r_shadow <= '0;
      r_pos    <= '0;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
`ifdef CALC_NEG_EN
      r_neg    <= 1'b0;
`endif
    end else begin
      r_state  <= w_state_nxt;
      r_ret    <= w_ret_nxt;
      r_value  <= w_value_nxt;
      r_rega   <= w_rega_nxt;
      r_regb   <= w_regb_nxt;
      r_op     <= w_op_nxt;
      r_fresh  <= w_fresh_nxt;
      r_shadow <= w_shadow_nxt;
      r_pos    <= w_pos_nxt;
      r_cnt    <= w_cnt_nxt;
      r_acc    <= w_acc_nxt;
      r_mcand  <= w_mcand_nxt;
      r_mplier <= w_mplier_nxt;
      r_rem    <= w_rem_nxt;
      r_quo    <= w_quo_nxt;
`ifdef CALC_NEG_EN
      r_neg    <= w_neg_nxt;
`endif
    end
  end

  assign pos   = r_pos;
  assign value = r_value;

endmodule

// File: tb/tb_calc_seq_n.sv
// tb_calc_seq_n: directed and random keypad sequences against an arithmetic calculator model.
module tb_calc_seq_n;
  localparam int     NDIG = 8;
  localparam int     VW   = 27;
  localparam int     PW   = $clog2(NDIG);
  localparam longint MAXV = longint'(10**NDIG) - 1;
  localparam longint MAXN = longint'(10**(NDIG-1)) - 1;
`ifdef CALC_NEG_EN
  localparam bit     NEG  = 1'b1;
`else
  localparam bit     NEG  = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic [3:0]    cmd = 4'd0;
  logic          cmd_valid = 1'b0;
  logic [1:0]    status;
  logic [3:0]    data;
  logic [PW-1:0] pos;
  logic [VW-1:0] value;

  calc_seq_n #(.NDIG(NDIG), .VW(VW)) dut (
    .clock(clock), .reset(reset), .cmd(cmd), .cmd_valid(cmd_valid),
    .status(status), .data(data), .pos(pos), .value(value)
  );

  always #5 clock = ~clock;

  int n_total = 0;
  int n_bad   = 0;

  longint m_val, m_a;
  int     m_op;
  bit     m_b, m_fresh, m_err, m_neg;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_val = 0; m_a = 0; m_op = 0; m_b = 0; m_fresh = 0; m_err = 0; m_neg = 0;
  endtask

  // ex = cycles spent computing before the scan starts (or before ERR shows)
  task automatic model_apply(input int c, output int ex, output bit er);
    longint r;
    bit ng;
    ex = 0; er = 0; r = 0; ng = 0;
    if (c <= 9) begin
      if (m_fresh) begin
        m_val = c; m_fresh = 0;
      end else if (m_val * 10 + c <= MAXV) begin
        m_val = m_val * 10 + c;
      end
      m_neg = 0;
    end else if (c == 15) begin
      m_val = m_val / 10;
    end else if (c == 14) begin
      if (m_b) begin
        ex = (m_op == 12 || m_op == 13) ? VW : 1;
        case (m_op)
          10: r = m_a + m_val;
          11: if (m_a >= m_val) r = m_a - m_val;
              else if (NEG) begin r = m_val - m_a; ng = 1; end
              else er = 1;
          12: r = m_a * m_val;
          default: if (m_val == 0) begin er = 1; ex = 1; end else r = m_a / m_val;
        endcase
        if (!er && r > (ng ? MAXN : MAXV)) er = 1;
        if (!er) begin
          m_val = r; m_fresh = 1; m_b = 0; m_neg = ng;
        end
      end
    end else begin
      if (!m_b) begin
        m_a = m_val; m_op = c; m_val = 0; m_b = 1;
      end else begin
        er = 1;
      end
      m_fresh = 0; m_neg = 0;
    end
    if (er) begin
      m_err = 1; m_val = 0;
    end
  endtask

  task automatic junk();
    cmd_valid = 1'($urandom_range(0, 1));
    cmd       = 4'($urandom_range(0, 15));
  endtask

  task automatic expect_scan(input string tag, input longint v, input bit ng);
    longint s;
    s = v;
    for (int k = 0; k < NDIG; k++) begin
      check({tag, "_busy"}, status, 2'b01);
      check({tag, "_pos"}, pos, k);
      check({tag, "_data"}, data, (ng && k == NDIG - 1) ? 10 : s % 10);
      s = s / 10;
      junk();
      @(negedge clock);
    end
    cmd_valid = 1'b0;
    check({tag, "_ready"}, status, 2'b10);
    check({tag, "_value"}, value, v);
  endtask

  task automatic do_reset();
    cmd_valid = 1'b0;
    reset = 1'b0;
    #1 reset = 1'b1;
    #1;
    check("rst_status", status, 2'b01);
    check("rst_value", value, 0);
    check("rst_pos", pos, 0);
    check("rst_data", data, 0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    model_reset();
    expect_scan("rst_scan", 0, 0);
  endtask

  task automatic send(input int c);
    int ex;
    bit er;
    cmd = 4'(c);
    cmd_valid = 1'b1;
    model_apply(c, ex, er);
    @(posedge clock);
    @(negedge clock);
    cmd_valid = 1'b0;
    for (int i = 0; i < ex; i++) begin
      check("exec_busy", status, 2'b01);
      junk();
      @(negedge clock);
    end
    if (er) begin
      for (int i = 0; i < 3; i++) begin
        check("err_status", status, 2'b00);
        check("err_value", value, 0);
        check("err_data", data, 0);
        check("err_pos", pos, 0);
        junk();
        @(negedge clock);
      end
      cmd_valid = 1'b0;
    end else begin
      expect_scan("scan", m_val, m_neg);
    end
  endtask

  task automatic enter(input longint n);
    int d[$];
    longint t;
    t = n;
    do begin
      d.push_front(int'(t % 10));
      t = t / 10;
    end while (t > 0);
    foreach (d[i]) send(d[i]);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int r, c;
    @(negedge clock);
    do_reset();

    enter(123);
    check("key_123", value, 123);
    send(15);
    check("bksp_12", value, 12);
    send(10);
    repeat (9) send(9);
    check("saturate", value, 99999999);
    send(14);
    check("sum_overflow", status, 2'b00);

    do_reset();
    enter(45); send(10); enter(78); send(14);
    check("add_45_78", value, 123);
    send(10); enter(7); send(14);
    check("chain_add", value, 130);
    send(5);
    check("fresh_clear", value, 5);

    do_reset();
    enter(1234); send(12); enter(5678); send(14);
    check("mul_1234_5678", value, 7006652);

    do_reset();
    enter(10000); send(12); enter(10000); send(14);
    check("mul_overflow", status, 2'b00);

    do_reset();
    enter(100); send(13); enter(7); send(14);
    check("div_100_7", value, 14);

    do_reset();
    enter(5); send(13); send(0); send(14);
    check("div_zero", status, 2'b00);

    do_reset();
    enter(12); send(12); enter(34);
    cmd = 4'd14; cmd_valid = 1'b1;
    @(posedge clock);
    @(negedge clock);
    cmd_valid = 1'b0;
    repeat (5) @(negedge clock);
    check("mid_mul_busy", status, 2'b01);
    do_reset();

    send(3); send(11); send(5); send(14);
    if (NEG) check("sub_neg", value, 2);
    else check("sub_neg_err", status, 2'b00);

    do_reset();
    for (int n = 0; n < 250; n++) begin
      r = $urandom_range(0, 99);
      if (r < 55) c = $urandom_range(0, 9);
      else if (r < 63) c = 15;
      else if (r < 80) c = 14;
      else c = $urandom_range(10, 13);
      send(c);
      if (m_err) do_reset();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
